product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N, default 4, operand width of the upstream multiplier; input product width is 2*N.
REQ-002 Parameter LEN, default 8, number of products summed per frame; legal range LEN >= 1.
REQ-003 Parameter ACC_W, default 2*N+4, accumulator and result width; legal range ACC_W >= 2*N.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_prod carries a valid product.
REQ-007 in_ready  output  1  block accepts in_prod this cycle.
REQ-008 in_prod  input  2*N  unsigned product from the multiplier stage.
REQ-009 out_valid  output  1  out_sum/out_ovf hold a completed frame result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_sum  output  ACC_W  frame sum.
REQ-012 out_ovf  output  1  one or more carries out of ACC_W bits occurred during the frame.

Function
REQ-013 Input handshake occurs on a rising edge with in_valid=1 and in_ready=1; output handshake occurs with out_valid=1 and out_ready=1.
REQ-014 FSM has two states: ACC and HOLD; reset state is ACC.
REQ-015 ACC: in_ready=1, out_valid=0; each input handshake adds zero-extended in_prod to the accumulator and increments the term counter.
REQ-016 ACC: the handshake that brings the count to LEN loads the final sum (including that product) into out_sum, sets out_valid=1 on the next cycle, and moves to HOLD.
REQ-017 Latency: out_valid rises exactly one cycle after the final input handshake of a frame.
REQ-018 HOLD: in_ready=0; out_valid, out_sum and out_ovf stay stable until the output handshake.
REQ-019 On the output handshake: state returns to ACC, accumulator, counter and overflow flag clear to 0, and out_valid drops the next cycle.
REQ-020 in_valid=0 cycles in ACC leave accumulator and counter unchanged; in_prod is ignored when no handshake occurs.
REQ-021 LEN=1: every accepted product forms a complete frame; out_sum equals that product.
REQ-022 Counter width is clog2(LEN+1); the counter never exceeds LEN.
REQ-023 out_ovf sets when an addition carries out of bit ACC_W-1, stays set for the rest of the frame, and is presented with out_sum.

Reset
REQ-024 While rst=1, regardless of clk: state=ACC, accumulator=0, counter=0, overflow flag=0, out_sum=0, out_ovf=0, out_valid=0.
REQ-025 While rst=1, in_ready=0; in_ready becomes 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-frame or in HOLD discards all partial and pending results; the next frame starts from zero.

Configuration
REQ-027 Macro ACC_SAT_EN selects overflow handling.
REQ-028 ACC_SAT_EN defined: on carry-out, the accumulator clamps to all ones (2^ACC_W-1) and holds that value for the rest of the frame; out_ovf=1.
REQ-029 ACC_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W; out_ovf=1.

Verification
REQ-030 N=4, LEN=4, ACC_W=12, four back-to-back products 225 -> out_valid one cycle after 4th handshake, out_sum=900, out_ovf=0.
REQ-031 Same config, out_ready held 0 for 5 cycles after out_valid -> out_valid, out_sum=900 stable, in_ready=0 throughout; handshake on cycle 6 -> in_ready=1 next cycle, new frame sums from 0.
REQ-032 N=4, LEN=2, ACC_W=8, products 225 and 225 -> without ACC_SAT_EN out_sum=194, out_ovf=1; with ACC_SAT_EN out_sum=255, out_ovf=1.
REQ-033 LEN=4, ACC_W=12, two products of 100 accepted, rst pulsed, then four products of 1 -> out_sum=4, out_ovf=0.
REQ-034 LEN=4, ACC_W=12, products 10,20,30,40 with in_valid low on alternate cycles and in_prod=255 while invalid -> out_sum=100.
REQ-035 LEN=1, ACC_W=8, N=4, products 7 then 9 each drained immediately -> two results, out_sum=7 then 9.

Source files
------------

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frame accumulator that sums LEN products and presents the sum with an overflow flag
// Define ACC_SAT_EN to saturate on carry-out instead of wrapping.
module product_accumulator #(
    parameter int N     = 4,
    parameter int LEN   = 8,
    parameter int ACC_W = 2*N+4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_ovf
);

    localparam int             CW   = $clog2(LEN+1);
    localparam logic [CW-1:0]  LAST = CW'(LEN-1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [CW-1:0]      cnt;
    logic               ovf;
    logic [ACC_W:0]     raw;
    logic [ACC_W-1:0]   acc_add;
    logic               in_fire;
    logic               out_fire;
    logic               last_term;

    assign raw = {1'b0, acc} + {{(ACC_W+1-2*N){1'b0}}, in_prod};

`ifdef ACC_SAT_EN
    // Once clamped, adding to all ones keeps carrying, so the clamp holds for the frame.
    assign acc_add = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    assign acc_add = raw[ACC_W-1:0];
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_term = (cnt == LAST);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = !rst;
                if (in_fire && last_term)
                    state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACC;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                acc <= acc_add;
                cnt <= cnt + 1'b1;
                ovf <= ovf | raw[ACC_W];
                if (last_term) begin
                    out_sum <= acc_add;
                    out_ovf <= ovf | raw[ACC_W];
                end
            end else if (out_fire) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized self-checking bench for product_accumulator
// Three instances: (LEN=4, ACC_W=12), (LEN=2, ACC_W=8), (LEN=1, ACC_W=8); honours ACC_SAT_EN.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [7:0]  in_prod   [3];
    wire         in_ready  [3];
    wire         out_valid [3];
    wire         out_ovf   [3];
    wire  [11:0] s0;
    wire  [7:0]  s1;
    wire  [7:0]  s2;
    wire  [11:0] sum_of    [3];

    int checks = 0;
    int errors = 0;

    assign sum_of[0] = s0;
    assign sum_of[1] = {4'b0, s1};
    assign sum_of[2] = {4'b0, s2};

    always #5 clk = ~clk;

    product_accumulator #(.N(4), .LEN(4), .ACC_W(12)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_prod(in_prod[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(s0), .out_ovf(out_ovf[0]));
    product_accumulator #(.N(4), .LEN(2), .ACC_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_prod(in_prod[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(s1), .out_ovf(out_ovf[1]));
    product_accumulator #(.N(4), .LEN(1), .ACC_W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_prod(in_prod[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(s2), .out_ovf(out_ovf[2]));

    function automatic int width_of(input int k);
        return (k == 0) ? 12 : 8;
    endfunction

    function automatic int len_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    // Reference: a frame result is the plain integer total, reduced by the overflow policy.
    function automatic int ref_sum(input int k, input int total);
        int maxv = (1 << width_of(k)) - 1;
        if (total <= maxv) return total;
`ifdef ACC_SAT_EN
        return maxv;
`else
        return total % (maxv + 1);
`endif
    endfunction

    function automatic int ref_ovf(input int k, input int total);
        return (total > (1 << width_of(k)) - 1) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int p, input int gap, input int garbage);
        int n;
        repeat (gap) begin
            in_valid[k] = 1'b0;
            in_prod[k]  = 8'(garbage);
            step();
        end
        in_valid[k] = 1'b1;
        in_prod[k]  = 8'(p);
        n = 0;
        while (!in_ready[k] && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("ready_timeout", in_ready[k], 1);
        step();
        in_valid[k] = 1'b0;
        in_prod[k]  = 8'(garbage);
    endtask

    // Called right after the final input handshake: result must already be valid.
    task automatic recv(input int k, input int es, input int eo, input int hold);
        chk("latency_valid", out_valid[k], 1);
        chk("sum", sum_of[k], es);
        chk("ovf", out_ovf[k], eo);
        repeat (hold) begin
            out_ready[k] = 1'b0;
            step();
            chk("hold_valid", out_valid[k], 1);
            chk("hold_sum", sum_of[k], es);
            chk("hold_in_ready", in_ready[k], 0);
        end
        out_ready[k] = 1'b1;
        step();
        out_ready[k] = 1'b0;
        chk("drop_valid", out_valid[k], 0);
        chk("resume_in_ready", in_ready[k], 1);
    endtask

    task automatic rand_frame(input int k);
        int total = 0;
        int p;
        for (int i = 0; i < len_of(k); i++) begin
            p = $urandom_range(255);
            total += p;
            send(k, p, $urandom_range(2), $urandom_range(255));
        end
        recv(k, ref_sum(k, total), ref_ovf(k, total), $urandom_range(3));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            in_prod[k]   = 8'd0;
        end
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", in_ready[k], 0);
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_sum", sum_of[k], 0);
            chk("rst_ovf", out_ovf[k], 0);
        end
        step();
        step();
        chk("rst_held_in_ready", in_ready[0], 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready[0], 1);
        step();

        // Four back-to-back 225s, then a 5-cycle stall on the output.
        for (int i = 0; i < 4; i++) send(0, 225, 0, 0);
        recv(0, ref_sum(0, 900), 0, 5);
        for (int i = 1; i <= 4; i++) send(0, i, 0, 0);
        recv(0, 10, 0, 0);

        // Overflow on a narrow accumulator.
        send(1, 225, 0, 0);
        send(1, 225, 0, 0);
`ifdef ACC_SAT_EN
        recv(1, 255, 1, 0);
`else
        recv(1, 194, 1, 0);
`endif

        // Reset mid-frame discards the partial sum.
        send(0, 100, 0, 0);
        send(0, 100, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", in_ready[0], 0);
        #3 rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) send(0, 1, 0, 0);
        recv(0, 4, 0, 0);

        // Alternate idle cycles with garbage on in_prod.
        for (int i = 1; i <= 4; i++) send(0, 10 * i, 1, 255);
        recv(0, 100, 0, 0);

        // Single-term frames.
        send(2, 7, 0, 0);
        recv(2, 7, 0, 0);
        send(2, 9, 0, 0);
        recv(2, 9, 0, 0);

        for (int f = 0; f < 12; f++) begin
            rand_frame(0);
            rand_frame(1);
            rand_frame(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
